// File: rtl/serdes_lane.sv
// Single-lane SERDES: sync-word aligned deserializer (RX) and double-buffered
// serializer (TX) with valid/ready handshake. RX and TX share only clk/rst_n/ena.
module serdes_lane #(
  parameter int               WIDTH     = 8,
  parameter bit               MSB_FIRST = 1'b1,
  parameter bit               ALIGN_EN  = 1'b1,
  parameter logic [WIDTH-1:0] SYNC_WORD = 8'hD5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             rx_bit,
  input  logic             rx_bit_en,
  input  logic             resync,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_locked,
  output logic             sync_det,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_active
);

  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } rx_state_t;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr, input logic b);
    return MSB_FIRST ? {sr[WIDTH-2:0], b} : {b, sr[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] sr);
    return MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
  endfunction

  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [WIDTH-1:0] rx_sr, rx_shifted;
  logic             rx_sample, rx_match, rx_word_done;

  // RX control: resync wins over the bit sampled on the same edge
  always_comb begin
    rx_shifted   = shift_in(rx_sr, rx_bit);
    rx_sample    = ena && rx_bit_en && !resync;
    rx_match     = rx_sample && (rx_state == HUNT) && (rx_shifted == SYNC_WORD);
    rx_word_done = rx_sample && (rx_state == LOCKED) && (rx_cnt == LAST_BIT);
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    if (ena && resync) begin
      rx_cnt_nxt   = '0;
      rx_state_nxt = ALIGN_EN ? HUNT : LOCKED;
    end else if (rx_sample) begin
      if (rx_state == HUNT) begin
        if (rx_match) begin
          rx_state_nxt = LOCKED;
          rx_cnt_nxt   = '0;
        end
      end else if (rx_word_done) begin
        rx_cnt_nxt = '0;
      end else begin
        rx_cnt_nxt = rx_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= ALIGN_EN ? HUNT : LOCKED;
      rx_cnt   <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
    end
  end

  // RX datapath; pulses clear on every edge they are not re-asserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      sync_det <= 1'b0;
    end else begin
      rx_valid <= rx_word_done;
      sync_det <= rx_match;
      if (rx_sample) rx_sr <= rx_shifted;
      if (rx_word_done) rx_data <= rx_shifted;
    end
  end

  assign rx_locked = (rx_state == LOCKED);

  logic [WIDTH-1:0] tx_hold, tx_sh;
  logic             tx_hold_full;
  logic [CNT_W-1:0] tx_cnt;
  logic             tx_last, tx_load, tx_take;

  // The shifter reloads on its last-bit edge so streamed words have no gap
  always_comb begin
    tx_last = tx_active && (tx_cnt == LAST_BIT);
    tx_load = ena && tx_hold_full && (!tx_active || tx_last);
    tx_take = ena && tx_valid && !tx_hold_full;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_hold      <= '0;
      tx_hold_full <= 1'b0;
      tx_sh        <= '0;
      tx_cnt       <= '0;
      tx_active    <= 1'b0;
    end else if (ena) begin
      if (tx_take) begin
        tx_hold      <= tx_data;
        tx_hold_full <= 1'b1;
      end else if (tx_load) begin
        tx_hold_full <= 1'b0;
      end
      if (tx_load) begin
        tx_sh     <= tx_hold;
        tx_cnt    <= '0;
        tx_active <= 1'b1;
      end else if (tx_last) begin
        tx_sh     <= '0;
        tx_cnt    <= '0;
        tx_active <= 1'b0;
      end else if (tx_active) begin
        tx_sh  <= shift_out(tx_sh);
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // Ready comes straight off the hold flag, so it rises only after a drain edge
  assign tx_ready = !tx_hold_full;
  assign tx_bit   = tx_active && (MSB_FIRST ? tx_sh[WIDTH-1] : tx_sh[0]);

endmodule

// File: tb/tb_serdes_lane.sv
// Bench for serdes_lane: an 8-bit MSB-first aligning lane and a 4-bit LSB-first
// free-running lane, checked against bit-stream level expectations.
module tb_serdes_lane;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, ena;

  logic       loop_mode, rx_bit_tb, rx_bit_en_tb, resync_m;
  logic       rx_bit_m, rx_bit_en_m;
  logic [7:0] rx_data_m, tx_data_m;
  logic       rx_valid_m, rx_locked_m, sync_det_m;
  logic       tx_valid_m, tx_ready_m, tx_bit_m, tx_active_m;

  logic       rx_bit_l, rx_bit_en_l, resync_l;
  logic [3:0] rx_data_l, tx_data_l;
  logic       rx_valid_l, rx_locked_l, sync_det_l;
  logic       tx_valid_l, tx_ready_l, tx_bit_l, tx_active_l;

  assign rx_bit_m    = loop_mode ? tx_bit_m : rx_bit_tb;
  assign rx_bit_en_m = loop_mode ? tx_active_m : rx_bit_en_tb;
  assign tx_data_l   = 4'h0;
  assign tx_valid_l  = 1'b0;

  serdes_lane u_m (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .rx_bit(rx_bit_m), .rx_bit_en(rx_bit_en_m), .resync(resync_m),
    .rx_data(rx_data_m), .rx_valid(rx_valid_m), .rx_locked(rx_locked_m), .sync_det(sync_det_m),
    .tx_data(tx_data_m), .tx_valid(tx_valid_m), .tx_ready(tx_ready_m),
    .tx_bit(tx_bit_m), .tx_active(tx_active_m)
  );

  serdes_lane #(.WIDTH(4), .MSB_FIRST(1'b0), .ALIGN_EN(1'b0), .SYNC_WORD(4'h5)) u_l (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .rx_bit(rx_bit_l), .rx_bit_en(rx_bit_en_l), .resync(resync_l),
    .rx_data(rx_data_l), .rx_valid(rx_valid_l), .rx_locked(rx_locked_l), .sync_det(sync_det_l),
    .tx_data(tx_data_l), .tx_valid(tx_valid_l), .tx_ready(tx_ready_l),
    .tx_bit(tx_bit_l), .tx_active(tx_active_l)
  );

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] tx_q[$];
  logic [7:0] got_q[$];
  logic       act_rec[$];
  logic       bit_rec[$];
  int         sync_cnt;
  logic [7:0] sw = 8'hD5;

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; ena = 1'b1; loop_mode = 1'b0;
    rx_bit_tb = 1'b0; rx_bit_en_tb = 1'b0; resync_m = 1'b0;
    tx_data_m = 8'h00; tx_valid_m = 1'b0;
    rx_bit_l = 1'b0; rx_bit_en_l = 1'b0; resync_l = 1'b0;
    cyc; cyc;
    rst_n = 1'b1;
    cyc;
  endtask

  // Drives the TX handshake from tx_q, records the wire and any RX words.
  task automatic run_tx(input int cycles);
    logic rdy;
    got_q.delete(); act_rec.delete(); bit_rec.delete(); sync_cnt = 0;
    rdy = tx_ready_m;
    for (int c = 0; c < cycles; c++) begin
      tx_valid_m = (tx_q.size() > 0);
      if (tx_valid_m) tx_data_m = tx_q[0];
      @(posedge clk);
      if (tx_valid_m && rdy) void'(tx_q.pop_front());
      #1;
      rdy = tx_ready_m;
      act_rec.push_back(tx_active_m);
      bit_rec.push_back(tx_bit_m);
      if (rx_valid_m) got_q.push_back(rx_data_m);
      if (sync_det_m) sync_cnt++;
    end
    tx_valid_m = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; loop_mode = 1'b0;
    rx_bit_tb = 1'b1; rx_bit_en_tb = 1'b1; resync_m = 1'b0;
    tx_data_m = 8'hFF; tx_valid_m = 1'b1;
    rx_bit_l = 1'b1; rx_bit_en_l = 1'b1; resync_l = 1'b0;
    cyc; cyc;
    n_chk++; if (rx_data_m !== 8'h00) $display("FAIL reset_rx_data got=%h exp=00", rx_data_m); else n_pass++;
    n_chk++; if (rx_valid_m !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid_m); else n_pass++;
    n_chk++; if (rx_locked_m !== 1'b0) $display("FAIL reset_rx_locked got=%b exp=0", rx_locked_m); else n_pass++;
    n_chk++; if (sync_det_m !== 1'b0) $display("FAIL reset_sync_det got=%b exp=0", sync_det_m); else n_pass++;
    n_chk++; if (tx_ready_m !== 1'b1) $display("FAIL reset_tx_ready got=%b exp=1", tx_ready_m); else n_pass++;
    n_chk++; if (tx_bit_m !== 1'b0) $display("FAIL reset_tx_bit got=%b exp=0", tx_bit_m); else n_pass++;
    n_chk++; if (tx_active_m !== 1'b0) $display("FAIL reset_tx_active got=%b exp=0", tx_active_m); else n_pass++;
    n_chk++; if (rx_locked_l !== 1'b1) $display("FAIL reset_lsb_locked got=%b exp=1", rx_locked_l); else n_pass++;
    n_chk++; if ({rx_data_l, rx_valid_l, sync_det_l} !== 6'b0)
      $display("FAIL reset_lsb_rx got=%b exp=000000", {rx_data_l, rx_valid_l, sync_det_l}); else n_pass++;
    n_chk++; if ({tx_ready_l, tx_bit_l, tx_active_l} !== 3'b100)
      $display("FAIL reset_lsb_tx got=%b exp=100", {tx_ready_l, tx_bit_l, tx_active_l}); else n_pass++;
    do_reset;
  endtask

  task automatic test_align;
    logic [18:0] pat = {3'b110, 8'hD5, 8'hA5};
    do_reset;
    for (int n = 1; n <= 19; n++) begin
      rx_bit_tb = pat[19-n]; rx_bit_en_tb = 1'b1;
      cyc;
      n_chk++; if (sync_det_m !== (n == 11)) $display("FAIL align_sync bit%0d got=%b exp=%b", n, sync_det_m, n == 11); else n_pass++;
      n_chk++; if (rx_valid_m !== (n == 19)) $display("FAIL align_valid bit%0d got=%b exp=%b", n, rx_valid_m, n == 19); else n_pass++;
      n_chk++; if (rx_locked_m !== (n >= 11)) $display("FAIL align_locked bit%0d got=%b exp=%b", n, rx_locked_m, n >= 11); else n_pass++;
    end
    n_chk++; if (rx_data_m !== 8'hA5) $display("FAIL align_data got=%h exp=a5", rx_data_m); else n_pass++;
    rx_bit_en_tb = 1'b0;
  endtask

  task automatic test_lsb_noalign;
    logic [7:0] pat = 8'b1000_0111;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      rx_bit_l = pat[7-i]; rx_bit_en_l = 1'b1;
      cyc;
      n_chk++; if (rx_valid_l !== (i == 3 || i == 7)) $display("FAIL lsb_valid bit%0d got=%b", i, rx_valid_l); else n_pass++;
      n_chk++; if (rx_locked_l !== 1'b1) $display("FAIL lsb_locked bit%0d got=%b exp=1", i, rx_locked_l); else n_pass++;
      if (i == 3) begin
        n_chk++; if (rx_data_l !== 4'h1) $display("FAIL lsb_data0 got=%h exp=1", rx_data_l); else n_pass++;
      end
    end
    n_chk++; if (rx_data_l !== 4'hE) $display("FAIL lsb_data1 got=%h exp=e", rx_data_l); else n_pass++;
    rx_bit_en_l = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_bits = {8'h3C, 8'hA5};
    int first = -1, last = -1, n_act = 0;
    do_reset;
    tx_q = '{8'h3C, 8'hA5};
    run_tx(30);
    for (int i = 0; i < act_rec.size(); i++) begin
      if (act_rec[i]) begin
        if (first < 0) first = i;
        last = i;
        n_act++;
        if (i - first < 16) begin
          n_chk++; if (bit_rec[i] !== exp_bits[15-(i-first)])
            $display("FAIL b2b_bit idx%0d got=%b exp=%b", i - first, bit_rec[i], exp_bits[15-(i-first)]); else n_pass++;
        end
      end else begin
        n_chk++; if (bit_rec[i] !== 1'b0) $display("FAIL b2b_idle_bit cyc%0d got=%b exp=0", i, bit_rec[i]); else n_pass++;
      end
    end
    n_chk++; if (n_act != 16) $display("FAIL b2b_active_cycles got=%0d exp=16", n_act); else n_pass++;
    n_chk++; if (first != 1) $display("FAIL b2b_latency got=%0d exp=1", first); else n_pass++;
    n_chk++; if (last - first != 15) $display("FAIL b2b_contiguous span got=%0d exp=15", last - first); else n_pass++;
  endtask

  task automatic test_loopback;
    logic [7:0] exp_q[$];
    do_reset;
    loop_mode = 1'b1;
    tx_q = '{8'hD5, 8'h11, 8'h22};
    run_tx(40);
    n_chk++; if (got_q.size() != 2) $display("FAIL loop_count got=%0d exp=2", got_q.size()); else n_pass++;
    n_chk++; if (got_q.size() > 0 && got_q[0] !== 8'h11) $display("FAIL loop_word0 got=%h exp=11", got_q[0]); else n_pass++;
    n_chk++; if (got_q.size() > 1 && got_q[1] !== 8'h22) $display("FAIL loop_word1 got=%h exp=22", got_q[1]); else n_pass++;
    n_chk++; if (rx_locked_m !== 1'b1) $display("FAIL loop_locked got=%b exp=1", rx_locked_m); else n_pass++;
    n_chk++; if (sync_cnt != 1) $display("FAIL loop_sync_count got=%0d exp=1", sync_cnt); else n_pass++;
    do_reset;
    loop_mode = 1'b1;
    tx_q = '{8'hD5};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'($urandom));
      tx_q.push_back(exp_q[i]);
    end
    run_tx(80);
    n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rloop_count got=%0d exp=%0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
        $display("FAIL rloop_word%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); else n_pass++;
    end
    loop_mode = 1'b0;
  endtask

  // Model: lock at the first stream window equal to the sync word, then cut the
  // rest of the stream into 8-bit words.
  task automatic test_random_rx;
    for (int it = 0; it < 3; it++) begin
      logic       b[64];
      logic [7:0] w;
      logic [7:0] exp_q[$];
      int         sync_at, p;
      int         got_sync[$];
      got_q.delete();
      for (int i = 0; i < 64; i++) b[i] = 1'($urandom_range(0, 1));
      p = $urandom_range(12, 40);
      for (int k = 0; k < 8; k++) b[p+k] = sw[7-k];
      sync_at = -1;
      for (int i = 7; i < 64; i++) begin
        if (sync_at < 0) begin
          w = 8'h00;
          for (int k = 0; k < 8; k++) w = {w[6:0], b[i-7+k]};
          if (w == 8'hD5) sync_at = i;
        end
      end
      for (int j = sync_at + 1; j + 7 <= 63; j += 8) begin
        w = 8'h00;
        for (int k = 0; k < 8; k++) w = {w[6:0], b[j+k]};
        exp_q.push_back(w);
      end
      do_reset;
      for (int i = 0; i < 64; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rx_bit_en_tb = 1'b0; rx_bit_tb = 1'($urandom_range(0, 1));
          cyc;
          if (sync_det_m) got_sync.push_back(i);
          if (rx_valid_m) got_q.push_back(rx_data_m);
        end
        rx_bit_en_tb = 1'b1; rx_bit_tb = b[i];
        cyc;
        if (sync_det_m) got_sync.push_back(i);
        if (rx_valid_m) got_q.push_back(rx_data_m);
      end
      rx_bit_en_tb = 1'b0;
      n_chk++; if (got_sync.size() != 1 || got_sync[0] != sync_at)
        $display("FAIL rrx_sync it%0d got_n=%0d exp_at=%0d", it, got_sync.size(), sync_at); else n_pass++;
      n_chk++; if (got_q.size() != exp_q.size()) $display("FAIL rrx_count it%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++; if (i >= got_q.size() || got_q[i] !== exp_q[i])
          $display("FAIL rrx_word it%0d w%0d got=%h exp=%h", it, i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] w = 8'h96;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      rx_bit_tb = sw[7-k]; rx_bit_en_tb = 1'b1;
      cyc;
      n_chk++; if (sync_det_m !== (k == 7)) $display("FAIL stall_sync k%0d got=%b", k, sync_det_m); else n_pass++;
    end
    ena = 1'b0;
    cyc;
    n_chk++; if (sync_det_m !== 1'b0) $display("FAIL stall_pulse_clear got=%b exp=0", sync_det_m); else n_pass++;
    n_chk++; if (rx_locked_m !== 1'b1) $display("FAIL stall_locked got=%b exp=1", rx_locked_m); else n_pass++;
    ena = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) begin
        ena = 1'b0;
        for (int s = 0; s < 3; s++) begin
          rx_bit_tb = 1'($urandom_range(0, 1));
          cyc;
          n_chk++; if ({rx_valid_m, rx_data_m} !== 9'h000) $display("FAIL stall_frozen s%0d got=%b/%h", s, rx_valid_m, rx_data_m); else n_pass++;
        end
        ena = 1'b1;
      end
      rx_bit_tb = w[7-k];
      cyc;
      n_chk++; if (rx_valid_m !== (k == 7)) $display("FAIL stall_valid k%0d got=%b", k, rx_valid_m); else n_pass++;
    end
    n_chk++; if (rx_data_m !== 8'h96) $display("FAIL stall_data got=%h exp=96", rx_data_m); else n_pass++;
  endtask

  task automatic test_resync;
    logic [23:0] s = {8'h00, 8'hD5, 8'h3C};
    logic [3:0]  lw = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      rx_bit_tb = k[0] ? 1'b0 : 1'b1; rx_bit_en_tb = 1'b1;
      cyc;
    end
    resync_m = 1'b1; rx_bit_tb = 1'b1;
    cyc;
    resync_m = 1'b0;
    n_chk++; if (rx_locked_m !== 1'b0) $display("FAIL resync_unlock got=%b exp=0", rx_locked_m); else n_pass++;
    for (int k = 0; k < 24; k++) begin
      rx_bit_tb = s[23-k];
      cyc;
      n_chk++; if (rx_valid_m !== (k == 23)) $display("FAIL resync_valid k%0d got=%b", k, rx_valid_m); else n_pass++;
      n_chk++; if (sync_det_m !== (k == 15)) $display("FAIL resync_sync k%0d got=%b", k, sync_det_m); else n_pass++;
    end
    n_chk++; if (rx_data_m !== 8'h3C) $display("FAIL resync_data got=%h exp=3c", rx_data_m); else n_pass++;
    rx_bit_en_tb = 1'b0;
    rx_bit_en_l = 1'b1; rx_bit_l = 1'b1;
    cyc; cyc;
    resync_l = 1'b1; rx_bit_l = 1'b0;
    cyc;
    resync_l = 1'b0;
    n_chk++; if (rx_locked_l !== 1'b1) $display("FAIL resync_lsb_locked got=%b exp=1", rx_locked_l); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      rx_bit_l = lw[k];
      cyc;
      n_chk++; if (rx_valid_l !== (k == 3)) $display("FAIL resync_lsb_valid k%0d got=%b", k, rx_valid_l); else n_pass++;
    end
    n_chk++; if (rx_data_l !== 4'hA) $display("FAIL resync_lsb_data got=%h exp=a", rx_data_l); else n_pass++;
    rx_bit_en_l = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      rx_bit_tb = sw[7-k]; rx_bit_en_tb = 1'b1;
      cyc;
    end
    rx_bit_tb = 1'b1;
    tx_data_m = 8'hFF; tx_valid_m = 1'b1;
    cyc;
    tx_valid_m = 1'b0;
    repeat (4) cyc;
    n_chk++; if ({tx_active_m, rx_locked_m} !== 2'b11) $display("FAIL rstmid_pre got=%b exp=11", {tx_active_m, rx_locked_m}); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (tx_active_m !== 1'b0) $display("FAIL rstmid_tx_active got=%b exp=0", tx_active_m); else n_pass++;
    n_chk++; if (tx_ready_m !== 1'b1) $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready_m); else n_pass++;
    n_chk++; if (rx_locked_m !== 1'b0) $display("FAIL rstmid_rx_locked got=%b exp=0", rx_locked_m); else n_pass++;
    n_chk++; if (tx_bit_m !== 1'b0) $display("FAIL rstmid_tx_bit got=%b exp=0", tx_bit_m); else n_pass++;
    rx_bit_en_tb = 1'b0;
    cyc;
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc;
      n_chk++; if ({tx_bit_m, tx_active_m, rx_valid_m} !== 3'b000)
        $display("FAIL rstmid_quiet cyc%0d got=%b exp=000", c, {tx_bit_m, tx_active_m, rx_valid_m}); else n_pass++;
    end
    n_chk++; if (rx_data_m !== 8'h00) $display("FAIL rstmid_rx_data got=%h exp=00", rx_data_m); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_align;
    test_lsb_noalign;
    test_back_to_back;
    test_loopback;
    test_random_rx;
    test_stall;
    test_resync;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached passed=%0d total=%0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serdes_lane.md
Name: serdes_lane

Overview:
- Parametrised single-lane SERDES; successor to the fixed 8-bit serial-in/byte-out block.
- Adds configurable word width, bit order, sync-word frame alignment with lock tracking, and a double-buffered serializer (TX) with valid/ready handshake.
- Sits between the top-level pin wrapper (serial pins) and the parallel datapath; one instance per lane.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = MSB first on the wire, 0 = LSB first; applies to RX and TX.
- ALIGN_EN, 1, 1 = RX hunts for SYNC_WORD before emitting words; 0 = RX locked from reset.
- SYNC_WORD, 8'hD5, WIDTH-bit alignment pattern, in wire order per MSB_FIRST.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- rx_bit  in  1  serial input bit.
- rx_bit_en  in  1  qualifies rx_bit on this edge.
- resync  in  1  forces RX back to HUNT.
- rx_data  out  WIDTH  last deserialized word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- rx_locked  out  1  RX aligned.
- sync_det  out  1  one-cycle pulse when SYNC_WORD is matched in HUNT.
- tx_data  in  WIDTH  word to serialize.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding register empty.
- tx_bit  out  1  serial output bit; 0 when idle.
- tx_active  out  1  tx_bit carries a data bit.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, except tx_ready=1 and rx_locked=ALIGN_EN?0:1. Internal state cleared: shift registers, counters, hold_full; RX state = ALIGN_EN?HUNT:LOCKED. Reset mid-word discards the partial word on both paths.
- Qualified edge: rising edge with ena=1. With ena=0, no sampling, shifting or handshake occurs; registered data outputs hold their values.
- rx_valid and sync_det are pulses: they clear on every edge on which they are not re-asserted, including edges with ena=0.
- RX shift on qualified edge with rx_bit_en=1:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], rx_bit}.
  - MSB_FIRST=0: sr <= {rx_bit, sr[WIDTH-1:1]}.
  - "next_sr" denotes this updated value.
- RX HUNT state (rx_locked=0): on each sampled bit, compare next_sr to SYNC_WORD. On match, at the same edge:
  - set sync_det=1 and rx_locked=1;
  - move to LOCKED and clear bit count;
  - the sync word itself is not emitted on rx_data.
- RX LOCKED state: bit count increments per sampled bit. On the WIDTH-th bit: rx_data <= next_sr, rx_valid=1, count wraps to 0. Latency: rx_valid is high in the cycle after the edge that sampled the last bit.
- resync=1 on a qualified edge: count cleared, bit on that edge discarded (resync has priority).
  - ALIGN_EN=1: state becomes HUNT and rx_locked=0.
  - ALIGN_EN=0: stays LOCKED; only the count is cleared.
- TX holding register: tx_ready = !hold_full, driven from a register. On a qualified edge with tx_valid && tx_ready, capture tx_data and set hold_full. tx_ready does not rise in the same cycle the hold register drains (no combinational path from the shifter).
- TX shifter:
  - When idle, or on the edge that shifts the last bit, with hold_full=1: load the shifter from hold, clear hold_full, tx_active=1.
  - tx_bit presents the current bit each cycle: MSB first if MSB_FIRST=1, otherwise LSB first. One bit per qualified edge.
  - After the last bit with hold empty: tx_active=0 and tx_bit=0.
- TX latency: word accepted at edge k; first bit appears on tx_bit after edge k+1.
- Continuous input: if tx_valid stays high, consecutive words stream with no idle bit between them.
- RX and TX are independent. Simultaneous resync and TX activity do not interact.

Test Plan:
- Alignment (WIDTH=8, MSB_FIRST=1, ALIGN_EN=1, SYNC=D5): bits 1,1,0 then D5 (11010101) then A5 (10100101) -> sync_det single pulse after the 11th bit; rx_locked=1 from then; exactly one rx_valid, with rx_data=8'hA5, after the 19th bit; no rx_valid before it.
- LSB-first, no align (WIDTH=4, MSB_FIRST=0, ALIGN_EN=0): bits 1,0,0,0,0,1,1,1 -> rx_valid twice, rx_data=4'h1 then 4'hE; rx_locked=1 from reset.
- TX back-to-back (WIDTH=8, MSB first): present 8'h3C then 8'hA5 with tx_valid held high -> tx_bit = 0011110010100101 over 16 consecutive cycles; tx_active high exactly 16 cycles; then tx_bit=0.
- Loopback: tx_bit→rx_bit with rx_bit_en=tx_active; send D5,11,22 -> rx_locked=1, then rx_data=8'h11 then 8'h22.
- Stall/resync: ena=0 for 3 cycles mid-word -> same rx_data, delivered 3 cycles later. resync pulse after 4 bits of a word -> rx_locked=0, no rx_valid until the next D5.
- Reset mid-operation: rst_n=0 mid-TX word, asynchronously -> tx_active=0, tx_ready=1, rx_locked=0 immediately; partial word never appears on tx_bit or rx_data.
